// File: rtl/qpd_multi_trigger_if.sv
// qpd_multi_trigger_if
// Groups the parameter, request and status signals of the multi-channel
// quarter-period delay trigger.
//   master : drives rt, arm_mode, count_quarter_period, pulse_len,
//            repeat_count, abort and clr_overrun; observes trigger, busy,
//            done and overrun.
//   slave  : the trigger block itself (mirror image of master).
interface qpd_multi_trigger_if #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 16,
  parameter int PULSE_W = 8,
  parameter int REP_W   = 8
);
  logic [NUM_CH-1:0]         rt;
  logic                      arm_mode;
  logic [NUM_CH*DELAY_W-1:0] count_quarter_period;
  logic [PULSE_W-1:0]        pulse_len;
  logic [REP_W-1:0]          repeat_count;
  logic [NUM_CH-1:0]         abort;
  logic                      clr_overrun;
  logic [NUM_CH-1:0]         trigger;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         done;
  logic [NUM_CH-1:0]         overrun;

  modport master (
    output rt, arm_mode, count_quarter_period, pulse_len, repeat_count,
           abort, clr_overrun,
    input  trigger, busy, done, overrun
  );

  modport slave (
    input  rt, arm_mode, count_quarter_period, pulse_len, repeat_count,
           abort, clr_overrun,
    output trigger, busy, done, overrun
  );
endinterface

// File: rtl/qpd_multi_trigger.sv
// qpd_multi_trigger
// NUM_CH independent channels. On an arm event a channel waits D+1 clocks
// (D = its quarter-period delay), then drives a trigger pulse of P' clocks,
// and repeats delay+pulse R' times in total before signalling done.
// Ports:
//   sclock : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of qpd_multi_trigger_if (requests, parameters,
//            abort/clear inputs; trigger/busy/done/overrun outputs, all
//            registered)
module qpd_multi_trigger #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 16,
  parameter int PULSE_W = 8,
  parameter int REP_W   = 8
) (
  input  logic                 sclock,
  input  logic                 rst_n,
  qpd_multi_trigger_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  localparam logic [PULSE_W-1:0] P_ZERO = {PULSE_W{1'b0}};
  localparam logic [PULSE_W-1:0] P_ONE  = {{(PULSE_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0]   R_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0]   R_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
  localparam logic [DELAY_W-1:0] D_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] D_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};

  state_t                           state_q [NUM_CH];
  state_t                           state_d [NUM_CH];
  logic [NUM_CH-1:0][DELAY_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0][DELAY_W-1:0]   dly_q, dly_d;
  logic [NUM_CH-1:0][DELAY_W-1:0]   stored_q, stored_d;
  logic [NUM_CH-1:0][PULSE_W-1:0]   pcnt_q, pcnt_d;
  logic [NUM_CH-1:0][PULSE_W-1:0]   plen_q, plen_d;
  logic [NUM_CH-1:0][REP_W-1:0]     rem_q, rem_d;
  logic [NUM_CH-1:0]                rt_prev_q;
  logic [NUM_CH-1:0]                trigger_q, trigger_d;
  logic [NUM_CH-1:0]                busy_q, busy_d;
  logic [NUM_CH-1:0]                done_q, done_d;
  logic [NUM_CH-1:0]                overrun_q, overrun_d;
  logic [NUM_CH-1:0]                arm_s;
  logic [DELAY_W-1:0]               slice_s;
  logic [PULSE_W-1:0]               p_eff_s;
  logic [REP_W-1:0]                 r_eff_s;

  // Next-state logic for every channel: arm detection, FSM, counters, flags
  always_comb begin
    p_eff_s   = (bus.pulse_len == P_ZERO) ? P_ONE : bus.pulse_len;
    r_eff_s   = (bus.repeat_count == R_ZERO) ? R_ONE : bus.repeat_count;
    slice_s   = D_ZERO;
    arm_s     = {NUM_CH{1'b0}};
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    stored_d  = stored_q;
    pcnt_d    = pcnt_q;
    plen_d    = plen_q;
    rem_d     = rem_q;
    trigger_d = trigger_q;
    done_d    = {NUM_CH{1'b0}};
    busy_d    = {NUM_CH{1'b0}};
    // a new overrun on this edge is OR-ed in below, so set beats clear
    overrun_d = bus.clr_overrun ? {NUM_CH{1'b0}} : overrun_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      slice_s    = bus.count_quarter_period[i*DELAY_W +: DELAY_W];
      if (bus.arm_mode) begin
        arm_s[i] = bus.rt[i] && (slice_s != stored_q[i]);
      end else begin
        arm_s[i] = bus.rt[i] && !rt_prev_q[i];
      end
      // mode-1 reference follows every arm event, accepted or not
      if (bus.arm_mode && arm_s[i]) begin
        stored_d[i] = slice_s;
      end else begin
        stored_d[i] = stored_q[i];
      end

      if (bus.abort[i]) begin
        state_d[i]   = ST_IDLE;
        trigger_d[i] = 1'b0;
        cnt_d[i]     = D_ZERO;
        pcnt_d[i]    = P_ZERO;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (arm_s[i]) begin
              dly_d[i]   = slice_s;
              plen_d[i]  = p_eff_s;
              rem_d[i]   = r_eff_s;
              cnt_d[i]   = D_ZERO;
              state_d[i] = ST_DELAY;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (arm_s[i]) begin
              overrun_d[i] = 1'b1;
            end else begin
              overrun_d[i] = overrun_d[i];
            end
            if (cnt_q[i] == dly_q[i]) begin
              cnt_d[i]     = D_ZERO;
              pcnt_d[i]    = P_ZERO;
              trigger_d[i] = 1'b1;
              state_d[i]   = ST_PULSE;
            end else begin
              cnt_d[i] = cnt_q[i] + D_ONE;
            end
          end
          ST_PULSE: begin
            if (arm_s[i]) begin
              overrun_d[i] = 1'b1;
            end else begin
              overrun_d[i] = overrun_d[i];
            end
            // pcnt counts completed pulse clocks minus one
            if (pcnt_q[i] == (plen_q[i] - P_ONE)) begin
              trigger_d[i] = 1'b0;
              pcnt_d[i]    = P_ZERO;
              if (rem_q[i] == R_ONE) begin
                rem_d[i]   = R_ZERO;
                done_d[i]  = 1'b1;
                state_d[i] = ST_IDLE;
              end else begin
                rem_d[i]   = rem_q[i] - R_ONE;
                cnt_d[i]   = D_ZERO;
                state_d[i] = ST_DELAY;
              end
            end else begin
              pcnt_d[i] = pcnt_q[i] + P_ONE;
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            trigger_d[i] = 1'b0;
          end
        endcase
      end
      busy_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge sclock) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
      cnt_q     <= {(NUM_CH*DELAY_W){1'b0}};
      dly_q     <= {(NUM_CH*DELAY_W){1'b0}};
      stored_q  <= {(NUM_CH*DELAY_W){1'b0}};
      pcnt_q    <= {(NUM_CH*PULSE_W){1'b0}};
      plen_q    <= {(NUM_CH*PULSE_W){1'b0}};
      rem_q     <= {(NUM_CH*REP_W){1'b0}};
      // history of 1 keeps an rt held through reset from looking like an edge
      rt_prev_q <= {NUM_CH{1'b1}};
      trigger_q <= {NUM_CH{1'b0}};
      busy_q    <= {NUM_CH{1'b0}};
      done_q    <= {NUM_CH{1'b0}};
      overrun_q <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      stored_q  <= stored_d;
      pcnt_q    <= pcnt_d;
      plen_q    <= plen_d;
      rem_q     <= rem_d;
      rt_prev_q <= bus.rt;
      trigger_q <= trigger_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.trigger = trigger_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: doc/qpd_multi_trigger.md
Name: qpd_multi_trigger

Overview:
- Multi-channel, parametrised successor to the quarter-period delay trigger.
- Each channel waits a programmable quarter-period delay after an arm event, then emits a programmable-width trigger pulse.
- A burst of pulses can be repeated a programmable number of times.
- Sits between the C-server-driven parameter registers and the measurement front end; one trigger output per detector channel.

Parameters:
NUM_CH, 4, number of independent trigger channels
DELAY_W, 16, width of quarter-period delay count per channel
PULSE_W, 8, width of pulse-length field
REP_W, 8, width of repeat-count field

Ports:
sclock  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
rt  in  NUM_CH  per-channel trigger request (level)
arm_mode  in  1  0 = arm on rt rising edge; 1 = arm when rt high and channel delay value changed
count_quarter_period  in  NUM_CH*DELAY_W  channel i delay D at [i*DELAY_W +: DELAY_W]
pulse_len  in  PULSE_W  pulse width P in clocks, shared (0 treated as 1)
repeat_count  in  REP_W  pulses per arm R, shared (0 treated as 1)
abort  in  NUM_CH  per-channel cancel
clr_overrun  in  1  clears all overrun flags
trigger  out  NUM_CH  registered trigger pulses
busy  out  NUM_CH  channel not IDLE
done  out  NUM_CH  1-cycle pulse when a burst completes normally
overrun  out  NUM_CH  sticky: arm event arrived while busy

Behaviour:
- Reset (rst_n=0 at an edge), with priority over everything:
  - all outputs 0, FSMs IDLE, counters 0, stored delay values 0.
  - rt history registers set to 1, so rt held high through reset does not arm in mode 0.
- Reset mid-operation: trigger drops on the reset edge; no done is issued.
- Arm event, channel i:
  - mode 0: rt[i]=1 and previous rt[i]=0.
  - mode 1: rt[i]=1 and slice != stored[i]; stored[i] updates to the slice on every mode-1 arm event, including one rejected as overrun.
- Per-channel FSM states: IDLE, DELAY, PULSE.
- IDLE + arm at edge k:
  - latch D, P'=max(P,1), R'=max(R,1); counter=0; go DELAY.
- DELAY: counter increments each clock. When counter==D: counter=0, trigger=1, go PULSE.
  - Result: trigger first high in the cycle after edge k+D+1.
- PULSE: trigger high for exactly P' clocks.
  - On the last pulse clock, decrement the remaining repeat count.
  - If repeats remain: trigger=0, counter=0, go DELAY. Rising-to-rising spacing is P'+D+1 clocks.
  - Otherwise: trigger=0, done=1 for one clock, go IDLE.
- Latched D/P'/R' are held for the whole burst; input changes mid-burst take effect only on the next arm.
- Arm event while not IDLE: ignored; overrun[i] set.
- clr_overrun and a new overrun on the same edge: set wins.
- abort[i]: channel returns to IDLE on that edge; trigger=0, no done.
- abort and arm on the same edge: abort wins; the arm is dropped and overrun is not set.
- busy[i]=1 whenever the FSM is not IDLE; registered, so it rises on edge k.
- Channels are fully independent; simultaneous arms on all channels are legal.
- Counters are DELAY_W/PULSE_W/REP_W wide and compare by equality. D=2^DELAY_W-1 must work with no wrap.
- D=0: trigger rises one clock after arm.

Test Plan:
- mode0, D=24, P=1, R=1 on ch0; rt rises at edge k -> trigger[0] high only in the cycle after edge k+25; done[0] on the following edge; busy high edges k..k+25.
- mode0, D=3, P=2, R=3 -> three 2-clock pulses, rising edges spaced 6 clocks; single done after the third pulse.
- mode1, rt held high on ch1, delay 25 -> 24 -> 24 -> exactly two bursts (one per change); no burst while the value is unchanged.
- Arm ch2 mid-DELAY -> burst unaffected, overrun[2]=1; clr_overrun -> 0. Abort during PULSE -> trigger drops next edge, no done.
- All 4 channels armed on the same edge with D=0,5,100,65535 -> each fires at its own D+1 latency. Reset asserted mid-pulse -> all outputs 0 on the reset edge; rt held high through reset does not arm.
